mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM stage: one load/store per request over a req/ack memory port, then result to MEM/WB.
// Latency >= 3 cycles (request, BUSY until ack, DONE); holds the pipeline via stall_req, DONE persists while stall[4].
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_w_enable,
  input  logic [4:0]  ex_w_addr,
  input  logic [31:0] ex_w_data,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [5:0]  stall,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        me_w_enable,
  output logic [4:0]  me_w_addr,
  output logic [31:0] me_w_data,
  output logic        me_misalign
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [31:0] result_q;
  logic        mem_req_q, mem_we_q, misalign_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wmask_q;

  logic        ex_is_load, ex_is_store, ex_is_mem, ex_misalign, q_is_load;
  logic [3:0]  st_mask;
  logic [31:0] st_data, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_misalign = 1'b0;
    st_mask     = 4'b0000;
    st_data     = 32'd0;
    case (ex_mem_op)
      OP_LB, OP_LBU: ex_is_load = 1'b1;
      OP_LH, OP_LHU: begin ex_is_load = 1'b1; ex_misalign = ex_w_data[0]; end
      OP_LW:         begin ex_is_load = 1'b1; ex_misalign = |ex_w_data[1:0]; end
      OP_SB: begin
        ex_is_store = 1'b1;
        st_mask     = 4'b0001 << ex_w_data[1:0];
        st_data     = {4{ex_store_data[7:0]}};
      end
      OP_SH: begin
        ex_is_store = 1'b1;
        ex_misalign = ex_w_data[0];
        st_mask     = ex_w_data[1] ? 4'b1100 : 4'b0011;
        st_data     = {2{ex_store_data[15:0]}};
      end
      OP_SW: begin
        ex_is_store = 1'b1;
        ex_misalign = |ex_w_data[1:0];
        st_mask     = 4'b1111;
        st_data     = ex_store_data;
      end
      default: ;
    endcase
    ex_is_mem = ex_is_load | ex_is_store;
  end

  // Lane selection uses the latched low address bits; misaligned halves/words fall back to the aligned lane.
  always_comb begin
    ld_byte = mem_rdata[8*lane_q +: 8];
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      OP_LW:   ld_val = mem_rdata;
      default: ld_val = 32'd0;
    endcase
    q_is_load = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                (op_q == OP_LBU) || (op_q == OP_LHU);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    stall_req   = 1'b0;
    me_w_enable = 1'b0;
    me_w_addr   = 5'd0;
    me_w_data   = 32'd0;
    case (state_q)
      IDLE: begin
        if (ex_is_mem) begin
          stall_req = 1'b1;
          state_d   = BUSY;
        end else begin
          me_w_enable = ex_w_enable;
          me_w_addr   = ex_w_addr;
          me_w_data   = ex_w_data;
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        if (q_is_load) begin
          me_w_enable = wen_q;
          me_w_addr   = rd_q;
          me_w_data   = result_q;
        end
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stall_req   = 1'b0;
      me_w_enable = 1'b0;
      me_w_addr   = 5'd0;
      me_w_data   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
      rd_q        <= 5'd0;
      wen_q       <= 1'b0;
      result_q    <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (state_q == IDLE && ex_is_mem) begin
        op_q        <= ex_mem_op;
        lane_q      <= ex_w_data[1:0];
        rd_q        <= ex_w_addr;
        wen_q       <= ex_w_enable;
        mem_req_q   <= 1'b1;
        mem_we_q    <= ex_is_store;
        mem_addr_q  <= {ex_w_data[31:2], 2'b00};
        mem_wmask_q <= st_mask;
        mem_wdata_q <= st_data;
        misalign_q  <= ex_misalign;
      end else if (state_q == BUSY && mem_ack) begin
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_wmask_q <= 4'd0;
        result_q    <= ld_val;
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign me_misalign = misalign_q;

endmodule
